// File: rtl/pop_pair_gen_if.sv
// pop_pair_gen_if -- parent-pair handshake between pop_pair_gen and the
// crossover stage.
//   pair_valid : producer -> consumer, a pair is presented
//   pair_ready : consumer -> producer, pair accepted when both high at clk edge
//   parent_a   : producer -> consumer, first parent population index
//   parent_b   : producer -> consumer, second parent population index
interface pop_pair_gen_if;
  logic       pair_valid;
  logic       pair_ready;
  logic [5:0] parent_a;
  logic [5:0] parent_b;

  modport master (output pair_valid, output parent_a, output parent_b, input pair_ready);
  modport slave  (input pair_valid, input parent_a, input parent_b, output pair_ready);
endinterface

// File: rtl/pop_pair_gen.sv
// pop_pair_gen -- parent-pair generator downstream of the population sorter.
// On a sort_done rise (in IDLE) it latches the ELITE best-ranked indices, then
// streams pseudo-random parent pairs drawn from that elite set.
// Optional feature macro: POP_PAIR_GEN_ELITISM_EN -- when defined, ELITE clone
// pairs (elite[r], elite[r]) precede the PAIRS random pairs.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sorted_in     : ranked index bus, rank r at [6r+5:6r]
//   sort_done     : sorter done level (rising edge triggers capture)
//   pair          : master side of pop_pair_gen_if (valid/ready + parents)
//   pair_count    : pairs accepted in the current generation
//   busy          : high in LOAD or EMIT
//   done          : one-cycle pulse after the last accepted pair
module pop_pair_gen #(
  parameter int          POP       = 50,
  parameter int          ELITE     = 10,
  parameter int          PAIRS     = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6*POP-1:0]     sorted_in,
  input  logic                 sort_done,
  pop_pair_gen_if.master       pair,
  output logic [5:0]           pair_count,
  output logic                 busy,
  output logic                 done
);
  localparam int RW = (ELITE > 1) ? $clog2(ELITE) : 1;
  localparam int PW = 8 + RW;
`ifdef POP_PAIR_GEN_ELITISM_EN
  localparam int TOTAL = ELITE + PAIRS;
`else
  localparam int TOTAL = PAIRS;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          sort_done_q;
  logic          valid_q;
  logic [5:0]    elite [ELITE];

  logic          trig;
  logic          xfer;
  logic          rnd_phase;
  logic [RW-1:0] clone_idx;
  logic [PW-1:0] prod_a, prod_b;
  logic [RW-1:0] rank_a, rank_b, rank_b_raw;
  logic [15:0]   lfsr_next;
  logic [5:0]    pa, pb;

  generate
    if (ELITE < POP) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^sorted_in[6*POP-1:6*ELITE];
    end
  endgenerate

  assign trig = sort_done & ~sort_done_q;
  assign xfer = valid_q & pair.pair_ready;

`ifdef POP_PAIR_GEN_ELITISM_EN
  // Clone pairs come first; pair_count doubles as the clone rank there.
  assign rnd_phase = (pair_count >= 6'(ELITE));
  assign clone_idx = pair_count[RW-1:0];
`else
  assign rnd_phase = 1'b1;
  assign clone_idx = '0;
`endif

  // Scale each LFSR byte into [0, ELITE) at full width so no rank overflows.
  assign prod_a     = PW'(lfsr[7:0])  * PW'(ELITE);
  assign prod_b     = PW'(lfsr[15:8]) * PW'(ELITE);
  assign rank_a     = RW'(prod_a >> 8);
  assign rank_b_raw = RW'(prod_b >> 8);
  // Collision bumps B to the next rank so the two parents always differ.
  assign rank_b     = (rank_b_raw != rank_a)       ? rank_b_raw :
                      (rank_a == RW'(ELITE - 1))   ? '0 : rank_a + 1'b1;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Parents come only from registers (lfsr, elite, pair_count, valid_q).
  always_comb begin
    pa = '0;
    pb = '0;
    if (valid_q) begin
      if (rnd_phase) begin
        pa = elite[rank_a];
        pb = elite[rank_b];
      end else begin
        pa = elite[clone_idx];
        pb = elite[clone_idx];
      end
    end
  end

  assign pair.pair_valid = valid_q;
  assign pair.parent_a   = pa;
  assign pair.parent_b   = pb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      pair_count  <= '0;
      sort_done_q <= 1'b1;  // a level held across reset is not a rise
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int r = 0; r < ELITE; r++) elite[r] <= '0;
    end else begin
      sort_done_q <= sort_done;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (trig) begin
            for (int r = 0; r < ELITE; r++) elite[r] <= sorted_in[6*r +: 6];
            pair_count <= '0;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          valid_q <= 1'b1;
          state   <= EMIT;
        end
        EMIT: begin
          if (xfer) begin
            pair_count <= pair_count + 6'd1;
            if (rnd_phase) lfsr <= lfsr_next;
            if (pair_count == 6'(TOTAL - 1)) begin
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pop_pair_gen.sv
module tb_pop_pair_gen;
  localparam int POP   = 50;
  localparam int ELITE = 10;
  localparam int PAIRS = 40;
`ifdef POP_PAIR_GEN_ELITISM_EN
  localparam int TOTAL = ELITE + PAIRS;
  localparam int CLONES = ELITE;
`else
  localparam int TOTAL = PAIRS;
  localparam int CLONES = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [6*POP-1:0] sorted_in;
  logic             sort_done;
  logic [5:0]       pair_count;
  logic             busy;
  logic             done;

  pop_pair_gen_if pif();

  pop_pair_gen #(.POP(POP), .ELITE(ELITE), .PAIRS(PAIRS), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .reset      (reset),
    .sorted_in  (sorted_in),
    .sort_done  (sort_done),
    .pair       (pif),
    .pair_count (pair_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_cnt;
  int          exp_elite [ELITE];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_pair(output int ea, output int eb);
    int ra, rb;
    if (m_cnt < CLONES) begin
      ea = exp_elite[m_cnt];
      eb = ea;
    end else begin
      ra = (int'(m_lfsr[7:0]) * ELITE) / 256;
      rb = (int'(m_lfsr[15:8]) * ELITE) / 256;
      if (rb == ra) rb = (ra == ELITE - 1) ? 0 : ra + 1;
      ea = exp_elite[ra];
      eb = exp_elite[rb];
    end
  endtask

  task automatic model_accept();
    if (m_cnt >= CLONES)
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_cnt++;
  endtask

  // Accept n pairs with pair_ready high, checking every pair against the model.
  task automatic run_xfers(input int n);
    int got = 0;
    int guard = 0;
    int ea, eb;
    pif.pair_ready = 1'b1;
    while (got < n && guard < 200) begin
      guard++;
      if (pif.pair_valid) begin
        model_pair(ea, eb);
        chk("parent_a", int'(pif.parent_a), ea);
        chk("parent_b", int'(pif.parent_b), eb);
        chk("pair_count", int'(pair_count), m_cnt);
        chk("no_early_done", int'(done), 0);
        if (m_cnt >= CLONES) chk("distinct_parents", int'(pif.parent_a != pif.parent_b), 1);
        model_accept();
        got++;
      end
      step();
    end
    chk("xfer_budget", got, n);
  endtask

  task automatic rise_and_wait_valid();
    sort_done = 1'b0;
    step();
    sort_done = 1'b1;
    step();
    chk("busy_load", int'(busy), 1);
    chk("valid_load", int'(pif.pair_valid), 0);
    step();
    chk("valid_emit", int'(pif.pair_valid), 1);
    chk("count_start", int'(pair_count), 0);
  endtask

  initial begin
    int a0, b0;
    reset = 1'b1;
    sort_done = 1'b0;
    pif.pair_ready = 1'b0;
    for (int r = 0; r < POP; r++) sorted_in[6*r +: 6] = 6'(49 - r);
    for (int r = 0; r < ELITE; r++) exp_elite[r] = 49 - r;
    m_lfsr = 16'hACE1;
    m_cnt = 0;
    step();
    step();
    chk("rst_valid", int'(pif.pair_valid), 0);
    chk("rst_pa", int'(pif.parent_a), 0);
    chk("rst_pb", int'(pif.parent_b), 0);
    chk("rst_count", int'(pair_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    step();

    // First pair from hand-computed values
    rise_and_wait_valid();
`ifdef POP_PAIR_GEN_ELITISM_EN
    chk("first_pa", int'(pif.parent_a), 49);
    chk("first_pb", int'(pif.parent_b), 49);
`else
    chk("first_pa", int'(pif.parent_a), 41);
    chk("first_pb", int'(pif.parent_b), 43);
`endif
    a0 = int'(pif.parent_a);
    b0 = int'(pif.parent_b);

    // Back-pressure: everything held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", int'(pif.pair_valid), 1);
      chk("stall_pa", int'(pif.parent_a), a0);
      chk("stall_pb", int'(pif.parent_b), b0);
      chk("stall_count", int'(pair_count), 0);
    end

    // Full generation
    run_xfers(TOTAL);
    chk("gen_done", int'(done), 1);
    chk("gen_count", int'(pair_count), TOTAL);
    chk("gen_valid_off", int'(pif.pair_valid), 0);
    step();
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    pif.pair_ready = 1'b0;

    // sort_done still high across a reset must not capture
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("no_capture_busy", int'(busy), 0);
    chk("no_capture_valid", int'(pif.pair_valid), 0);
    m_lfsr = 16'hACE1;
    m_cnt = 0;

    // Fresh rise captures; a second rise during EMIT is ignored
    rise_and_wait_valid();
    a0 = int'(pif.parent_a);
    b0 = int'(pif.parent_b);
    sort_done = 1'b0;
    step();
    sort_done = 1'b1;
    step();
    step();
    chk("ignore_valid", int'(pif.pair_valid), 1);
    chk("ignore_busy", int'(busy), 1);
    chk("ignore_pa", int'(pif.parent_a), a0);
    chk("ignore_pb", int'(pif.parent_b), b0);

    // Reset on the 20th transfer
    run_xfers(19);
    chk("pre_rst_valid", int'(pif.pair_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    pif.pair_ready = 1'b0;
    chk("midrst_valid", int'(pif.pair_valid), 0);
    chk("midrst_count", int'(pair_count), 0);
    chk("midrst_busy", int'(busy), 0);
    m_lfsr = 16'hACE1;
    m_cnt = 0;

    // Replay matches the first test
    rise_and_wait_valid();
`ifdef POP_PAIR_GEN_ELITISM_EN
    chk("replay_pa", int'(pif.parent_a), 49);
    chk("replay_pb", int'(pif.parent_b), 49);
`else
    chk("replay_pa", int'(pif.parent_a), 41);
    chk("replay_pb", int'(pif.parent_b), 43);
`endif
    run_xfers(TOTAL);
    chk("replay_done", int'(done), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/pop_pair_gen.md
# pop_pair_gen

Parent-pair generator that sits directly downstream of the population sorter in the genetic brew-run pipeline. When the sorter reports completion, it captures the best ELITE individual indices from the sorter's 300-bit ranked index bus (rank 0 = lowest distance). It then streams parent index pairs, chosen pseudo-randomly from that elite set, to the crossover stage over a valid/ready handshake. One capture yields one generation's worth of pairs, after which the block returns to idle for the next generation.

## Interface
- POP, 50: population size; ranked bus holds POP 6-bit indices.
- ELITE, 10: number of top ranks eligible as parents; 2..POP.
- PAIRS, 40: random pairs emitted per generation; 1..63.
- LFSR_SEED, 16'hACE1: LFSR value at reset; must be nonzero.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sorted_in  in  6*POP  ranked index bus; rank r occupies bits [6r+5:6r].
- sort_done  in  1  sorter done level; held high while the sorter sits in its done state.
- pair_valid  out  1  parent_a/parent_b hold a valid pair.
- pair_ready  in  1  consumer accepts the pair when high together with pair_valid.
- parent_a  out  6  first parent index (population index, not rank).
- parent_b  out  6  second parent index.
- pair_count  out  6  pairs accepted in the current generation.
- busy  out  1  high in LOAD or EMIT.
- done  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- States: IDLE, LOAD, EMIT, DONE. State is encoded in 2 bits.
- sort_done edge detection:
  - sort_done_q is registered each cycle.
  - A capture triggers only on sort_done & ~sort_done_q, and only while in IDLE.
  - A rise seen in any other state is ignored.
- IDLE → LOAD on trigger. That cycle latches elite[r] = sorted_in[6r+5:6r] for r = 0..ELITE-1.
- LOAD → EMIT unconditionally on the next cycle. pair_count is cleared on entering LOAD.
- Random pair selection in EMIT:
  - rank_a = (lfsr[7:0] * ELITE) >> 8.
  - rank_b = (lfsr[15:8] * ELITE) >> 8.
  - If rank_b == rank_a, rank_b = rank_a + 1, wrapping to 0 when rank_a == ELITE-1.
  - parent_a = elite[rank_a]; parent_b = elite[rank_b].
  - Products are computed at full width (8 + clog2(ELITE) bits), so ranks are always < ELITE.
- LFSR:
  - 16-bit Galois, shift right, XOR mask 16'hB400 applied when the shifted-out bit is 1.
  - Advances exactly once per accepted random pair and holds otherwise.
  - Not reinitialised between generations.
- Handshake:
  - In EMIT, pair_valid = 1. Elsewhere pair_valid = 0.
  - A transfer occurs on pair_valid & pair_ready at a clock edge. pair_count increments by one per transfer.
  - While pair_ready = 0, parent_a, parent_b and pair_valid are held stable.
- EMIT → DONE on the transfer that makes pair_count equal to the total pair count. DONE → IDLE after one cycle; done = 1 only in DONE.
- Reset, including mid-operation:
  - State → IDLE, lfsr → LFSR_SEED, pair_count → 0, elite → 0.
  - sort_done_q → 1, so a sort_done level still high across reset does not trigger a capture.

## Timing
- Reset values: pair_valid 0, parent_a 0, parent_b 0, pair_count 0, busy 0, done 0.
- parent_a, parent_b and pair_valid depend only on registered state, with no combinational path from any input.
- Sort_done rise at edge N: capture at edge N, pair_valid high after edge N+1. The first pair is visible 2 cycles after the rise.
- With pair_ready held high, one pair transfers per cycle. done pulses in the cycle after the last transfer.
- Minimum generation time is total pair count + 3 cycles from the sort_done rise to the return to IDLE.

## Configuration
- POP_PAIR_GEN_ELITISM_EN defined:
  - EMIT first produces ELITE clone pairs, with parent_a = parent_b = elite[r] for r = 0..ELITE-1.
  - The LFSR does not advance during clone pairs.
  - PAIRS random pairs follow; total pair count = ELITE + PAIRS (default 50).
- Not defined: only the PAIRS random pairs are emitted; total pair count = PAIRS.

## Test plan
- Reset, then sorted_in with rank r = index 49-r, sort_done rises, pair_ready = 1, macro undefined → first pair parent_a = 41 (rank 8), parent_b = 43 (rank 6).
- Same stimulus with pair_ready held low for 5 cycles after valid → outputs stable for all 5 cycles, pair_count stays 0, LFSR unchanged.
- Full generation with pair_ready = 1 → exactly 40 transfers, done pulses once in the cycle after transfer 40, pair_count = 40, and parent_a ≠ parent_b for every pair.
- sort_done held high across reset and released → no capture. A later 0→1 rise → capture; a second rise during EMIT → ignored.
- Reset asserted at transfer 20 → next cycle pair_valid = 0, pair_count = 0, state IDLE. A new rise replays the same first pair as the first test.
- POP_PAIR_GEN_ELITISM_EN defined, first-test stimulus → first 10 pairs are (49,49), (48,48) … (40,40). Pair 11 = (41,43). done after 50 transfers.
